// File: rtl/qr_unmask.sv
`default_nettype none
// ============================================================================
// Module   : qr_unmask
// Purpose  : Takes a captured 21x21 version-1 QR module grid, checks that the
//            two format-information copies agree, decodes ECC level and mask
//            id, then removes the data mask one module per cycle (raster
//            order, column fastest) leaving function patterns untouched.
// Ports    : clk_in        system clock
//            rst_in        synchronous active-high reset
//            qr_code       input grid, bit [col + 21*row], 1 = dark
//            valid_qr      one-cycle pulse, qr_code valid this cycle
//            unmasked_code unmasked grid, same indexing as qr_code
//            ecc_level     format bits [14:13] after FORMAT_XOR
//            mask_id       format bits [12:10] after FORMAT_XOR
//            format_err    format copies disagree (held until next capture)
//            unmask_valid  one-cycle pulse: outputs are final
//            busy          high while checking format or unmasking
// Revision : 1.0 - initial release
// ============================================================================
module qr_unmask #(
    parameter int          CODE_SIZE  = 21,
    parameter logic [14:0] FORMAT_XOR = 15'h5412
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [CODE_SIZE*CODE_SIZE-1:0] qr_code,
    input  logic                           valid_qr,
    output logic [CODE_SIZE*CODE_SIZE-1:0] unmasked_code,
    output logic [1:0]                     ecc_level,
    output logic [2:0]                     mask_id,
    output logic                           format_err,
    output logic                           unmask_valid,
    output logic                           busy
);

    localparam int         C_N     = CODE_SIZE;
    localparam int         C_CELLS = CODE_SIZE * CODE_SIZE;
    localparam int         C_IDX_W = $clog2(C_CELLS);
    localparam logic [4:0] C_LAST  = 5'(CODE_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FORMAT = 2'd1,
        S_UNMASK = 2'd2
    } state_t;

    state_t               r_state;
    logic [C_CELLS-1:0]   r_grid;
    logic [4:0]           r_row;
    logic [4:0]           r_col;
    logic [C_IDX_W-1:0]   r_idx;       // row*21 + col, advanced alongside row/col
    logic [1:0]           r_row_m3;    // row % 3
    logic [1:0]           r_col_m3;    // col % 3
    logic                 r_col_d3;    // (col / 3) % 2

    logic [14:0]          w_copy_a;
    logic [14:0]          w_copy_b;
    logic                 w_func;
    logic                 w_mask_hit;
    logic                 w_flip;
    logic                 w_p2;        // (row*col) % 2
    logic [1:0]           w_p3;        // (row*col) % 3
    logic [2:0]           w_s3;        // row%3 + col%3, range 0..4
    logic                 w_s3_zero;   // (row+col) % 3 == 0
    logic                 w_last;

    assign unmasked_code = r_grid;

    // Gather both format copies from the captured grid.
    always_comb begin
        w_copy_a = '0;
        w_copy_b = '0;
        for (int k = 0; k < 6; k++) begin
            w_copy_a[14-k] = r_grid[8*C_N + k];
            w_copy_a[k]    = r_grid[k*C_N + 8];
        end
        w_copy_a[8] = r_grid[8*C_N + 7];
        w_copy_a[7] = r_grid[8*C_N + 8];
        w_copy_a[6] = r_grid[7*C_N + 8];
        for (int k = 0; k < 7; k++) begin
            w_copy_b[14-k] = r_grid[(20-k)*C_N + 8];
        end
        for (int k = 0; k < 8; k++) begin
            w_copy_b[7-k] = r_grid[8*C_N + 13 + k];
        end
    end

    // Finder/separator/format areas plus both timing lines are never masked.
    assign w_func = ((r_row <= 5'd8) && ((r_col <= 5'd8) || (r_col >= 5'd13))) ||
                    ((r_row >= 5'd13) && (r_col <= 5'd8)) ||
                    (r_row == 5'd6) || (r_col == 5'd6);

    // Products and sums modulo 2/3 are derived from the running residues so
    // no multiplier or divider is needed.
    assign w_p2      = r_row[0] & r_col[0];
    assign w_p3      = ((r_row_m3 == 2'd0) || (r_col_m3 == 2'd0)) ? 2'd0 :
                       (r_row_m3 == r_col_m3)                     ? 2'd1 : 2'd2;
    assign w_s3      = {1'b0, r_row_m3} + {1'b0, r_col_m3};
    assign w_s3_zero = (w_s3 == 3'd0) || (w_s3 == 3'd3);

    always_comb begin
        w_mask_hit = 1'b0;
        case (mask_id)
            3'd0:    w_mask_hit = ~(r_row[0] ^ r_col[0]);
            3'd1:    w_mask_hit = ~r_row[0];
            3'd2:    w_mask_hit = (r_col_m3 == 2'd0);
            3'd3:    w_mask_hit = w_s3_zero;
            3'd4:    w_mask_hit = ~(r_row[1] ^ r_col_d3);
            3'd5:    w_mask_hit = ~w_p2 && (w_p3 == 2'd0);
            3'd6:    w_mask_hit = ~(w_p2 ^ w_p3[0]);
            3'd7:    w_mask_hit = ~(r_row[0] ^ r_col[0] ^ w_p3[0]);
            default: w_mask_hit = 1'b0;
        endcase
    end

    assign w_flip = w_mask_hit & ~w_func;
    assign w_last = (r_row == C_LAST) && (r_col == C_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_grid       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_idx        <= '0;
            r_row_m3     <= '0;
            r_col_m3     <= '0;
            r_col_d3     <= 1'b0;
            ecc_level    <= '0;
            mask_id      <= '0;
            format_err   <= 1'b0;
            unmask_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            unmask_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_qr) begin
                        r_grid     <= qr_code;
                        format_err <= 1'b0;
                        ecc_level  <= '0;
                        mask_id    <= '0;
                        busy       <= 1'b1;
                        r_state    <= S_FORMAT;
                    end
                end
                S_FORMAT: begin
                    if (w_copy_a != w_copy_b) begin
                        format_err   <= 1'b1;
                        unmask_valid <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        ecc_level <= w_copy_a[14:13] ^ FORMAT_XOR[14:13];
                        mask_id   <= w_copy_a[12:10] ^ FORMAT_XOR[12:10];
                        r_row     <= '0;
                        r_col     <= '0;
                        r_idx     <= '0;
                        r_row_m3  <= '0;
                        r_col_m3  <= '0;
                        r_col_d3  <= 1'b0;
                        r_state   <= S_UNMASK;
                    end
                end
                S_UNMASK: begin
                    r_grid[r_idx] <= r_grid[r_idx] ^ w_flip;
                    if (w_last) begin
                        unmask_valid <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        if (r_col == C_LAST) begin
                            r_col    <= '0;
                            r_col_m3 <= '0;
                            r_col_d3 <= 1'b0;
                            r_row    <= r_row + 5'd1;
                            r_row_m3 <= (r_row_m3 == 2'd2) ? 2'd0 : r_row_m3 + 2'd1;
                        end else begin
                            r_col <= r_col + 5'd1;
                            if (r_col_m3 == 2'd2) begin
                                r_col_m3 <= 2'd0;
                                r_col_d3 <= ~r_col_d3;
                            end else begin
                                r_col_m3 <= r_col_m3 + 2'd1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qr_unmask.sv
`default_nettype none
// ============================================================================
// Module   : tb_qr_unmask
// Purpose  : Self-checking bench for qr_unmask. Expected frames are produced
//            by a behavioural model when a grid is sent and compared when the
//            DUT signals completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qr_unmask;

    localparam int N     = 21;
    localparam int CELLS = N * N;
    localparam int GOOD_LAT = 442;
    localparam int ERR_LAT  = 1;

    // Format bit positions, listed for bits 14 down to 0.
    localparam int AR[15] = '{8, 8, 8, 8, 8, 8, 8, 8, 7, 5, 4, 3, 2, 1, 0};
    localparam int AC[15] = '{0, 1, 2, 3, 4, 5, 7, 8, 8, 8, 8, 8, 8, 8, 8};
    localparam int BR[15] = '{20, 19, 18, 17, 16, 15, 14, 8, 8, 8, 8, 8, 8, 8, 8};
    localparam int BC[15] = '{8, 8, 8, 8, 8, 8, 8, 13, 14, 15, 16, 17, 18, 19, 20};

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [CELLS-1:0] qr_code;
    logic             valid_qr;
    logic [CELLS-1:0] unmasked_code;
    logic [1:0]       ecc_level;
    logic [2:0]       mask_id;
    logic             format_err;
    logic             unmask_valid;
    logic             busy;

    typedef struct {
        logic [CELLS-1:0] grid;
        logic [1:0]       ecc;
        logic [2:0]       mask;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    qr_unmask #(.CODE_SIZE(21), .FORMAT_XOR(15'h5412)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .qr_code      (qr_code),
        .valid_qr     (valid_qr),
        .unmasked_code(unmasked_code),
        .ecc_level    (ecc_level),
        .mask_id      (mask_id),
        .format_err   (format_err),
        .unmask_valid (unmask_valid),
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    function automatic int ix(input int r, input int c);
        return c + N * r;
    endfunction

    function automatic logic [CELLS-1:0] put_fmt(input logic [CELLS-1:0] g,
                                                 input logic [14:0] a,
                                                 input logic [14:0] b);
        logic [CELLS-1:0] t;
        t = g;
        for (int k = 0; k < 15; k++) begin
            t[ix(AR[k], AC[k])] = a[14-k];
            t[ix(BR[k], BC[k])] = b[14-k];
        end
        return t;
    endfunction

    function automatic bit is_func(input int i, input int j);
        return (i < 9 && (j < 9 || j > 12)) || (i > 12 && j < 9) || i == 6 || j == 6;
    endfunction

    function automatic bit mask_cond(input int m, input int i, input int j);
        case (m)
            0: return (i + j) % 2 == 0;
            1: return i % 2 == 0;
            2: return j % 3 == 0;
            3: return (i + j) % 3 == 0;
            4: return (i / 2 + j / 3) % 2 == 0;
            5: return (i * j) % 2 + (i * j) % 3 == 0;
            6: return ((i * j) % 2 + (i * j) % 3) % 2 == 0;
            default: return ((i + j) % 2 + (i * j) % 3) % 2 == 0;
        endcase
    endfunction

    function automatic exp_t model(input logic [CELLS-1:0] g);
        exp_t        e;
        logic [14:0] a;
        logic [14:0] b;
        logic [14:0] f;
        for (int k = 0; k < 15; k++) begin
            a[14-k] = g[ix(AR[k], AC[k])];
            b[14-k] = g[ix(BR[k], BC[k])];
        end
        e.grid = g;
        if (a != b) begin
            e.ecc  = 2'd0;
            e.mask = 3'd0;
            e.err  = 1'b1;
        end else begin
            f      = a ^ 15'h5412;
            e.ecc  = f[14:13];
            e.mask = f[12:10];
            e.err  = 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (!is_func(i, j) && mask_cond(int'(e.mask), i, j))
                        e.grid[ix(i, j)] = ~g[ix(i, j)];
        end
        return e;
    endfunction

    function automatic logic [CELLS-1:0] rand_grid();
        logic [CELLS-1:0] g;
        for (int k = 0; k < CELLS; k++) g[k] = 1'($urandom_range(0, 1));
        return g;
    endfunction

    // Pulse valid_qr for one cycle and record the expected frame.
    task automatic send(input logic [CELLS-1:0] g);
        qr_code  = g;
        valid_qr = 1'b1;
        sb.push_back(model(g));
        @(posedge clk_in);
        #1;
        valid_qr = 1'b0;
    endtask

    // Count negedges after the capture edge until unmask_valid (or give up).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk_in);
            if (unmask_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst_in   = 1'b1;
        valid_qr = 1'b0;
        qr_code  = '0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({unmasked_code !== '0, ecc_level, mask_id, format_err, unmask_valid, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs actual ecc=%b mask=%b err=%b v=%b busy=%b grid_nonzero=%b required all 0",
                     ecc_level, mask_id, format_err, unmask_valid, busy, unmasked_code !== '0);
        end
        e.grid = '0;
    endtask

    task automatic test_mask0_zero();
        exp_t e;
        int   lat;
        @(posedge clk_in); #1;
        send(put_fmt('0, 15'h77C4, 15'h77C4));
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== GOOD_LAT) begin failures++; $display("FAIL t1_latency actual=%0d required=%0d", lat, GOOD_LAT); end
        checks++;
        if (ecc_level !== 2'b01 || mask_id !== 3'd0 || format_err !== 1'b0) begin
            failures++;
            $display("FAIL t1_fields actual ecc=%b mask=%0d err=%b required ecc=01 mask=0 err=0", ecc_level, mask_id, format_err);
        end
        checks++;
        if (unmasked_code[ix(9, 9)] !== 1'b1 || unmasked_code[ix(9, 10)] !== 1'b0 || unmasked_code[ix(0, 0)] !== 1'b0) begin
            failures++;
            $display("FAIL t1_points actual (9,9)=%b (9,10)=%b (0,0)=%b required 1 0 0",
                     unmasked_code[ix(9, 9)], unmasked_code[ix(9, 10)], unmasked_code[ix(0, 0)]);
        end
        checks++;
        if (unmasked_code !== e.grid) begin
            failures++;
            $display("FAIL t1_grid actual=%h required=%h", unmasked_code, e.grid);
        end
    endtask

    task automatic test_format_err();
        exp_t             e;
        int               lat;
        logic [CELLS-1:0] g;
        @(posedge clk_in); #1;
        g = put_fmt('0, 15'h77C4, 15'h77C5);
        send(g);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== ERR_LAT) begin failures++; $display("FAIL t2_latency actual=%0d required=%0d", lat, ERR_LAT); end
        checks++;
        if (format_err !== 1'b1 || busy !== 1'b0 || ecc_level !== 2'd0 || mask_id !== 3'd0) begin
            failures++;
            $display("FAIL t2_flags actual err=%b busy=%b ecc=%b mask=%0d required err=1 busy=0 ecc=00 mask=0",
                     format_err, busy, ecc_level, mask_id);
        end
        checks++;
        if (unmasked_code !== g || e.err !== 1'b1) begin
            failures++;
            $display("FAIL t2_grid actual=%h required=%h", unmasked_code, g);
        end
    endtask

    task automatic test_mask1_ones();
        exp_t e;
        int   lat;
        @(posedge clk_in); #1;
        send(put_fmt('1, 15'h72F3, 15'h72F3));
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== GOOD_LAT || mask_id !== 3'd1 || format_err !== 1'b0) begin
            failures++;
            $display("FAIL t3_fields actual lat=%0d mask=%0d err=%b required lat=%0d mask=1 err=0", lat, mask_id, format_err, GOOD_LAT);
        end
        checks++;
        if (unmasked_code[ix(10, 12)] !== 1'b0 || unmasked_code[ix(11, 12)] !== 1'b1 ||
            unmasked_code[ix(0, 0)] !== 1'b1 || unmasked_code[ix(20, 0)] !== 1'b1 || unmasked_code[ix(0, 20)] !== 1'b1) begin
            failures++;
            $display("FAIL t3_points actual (10,12)=%b (11,12)=%b finders=%b%b%b required 0 1 111",
                     unmasked_code[ix(10, 12)], unmasked_code[ix(11, 12)], unmasked_code[ix(0, 0)],
                     unmasked_code[ix(20, 0)], unmasked_code[ix(0, 20)]);
        end
        checks++;
        if (unmasked_code !== e.grid) begin failures++; $display("FAIL t3_grid actual=%h required=%h", unmasked_code, e.grid); end
    endtask

    task automatic test_timing_row();
        exp_t             e;
        int               lat;
        logic [CELLS-1:0] g;
        @(posedge clk_in); #1;
        g = put_fmt('0, 15'h77C4, 15'h77C4);
        g[ix(6, 10)] = 1'b1;
        send(g);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== GOOD_LAT || unmasked_code[ix(6, 10)] !== 1'b1 || unmasked_code[ix(10, 6)] !== 1'b0) begin
            failures++;
            $display("FAIL t4_timing actual lat=%0d (6,10)=%b (10,6)=%b required lat=%0d 1 0",
                     lat, unmasked_code[ix(6, 10)], unmasked_code[ix(10, 6)], GOOD_LAT);
        end
        checks++;
        if (unmasked_code !== e.grid) begin failures++; $display("FAIL t4_grid actual=%h required=%h", unmasked_code, e.grid); end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int   pulses;
        int   pulse_at;
        int   busy_bad;
        @(posedge clk_in); #1;
        send(put_fmt(rand_grid(), 15'h6976, 15'h6976));
        pulses = 0; pulse_at = -1; busy_bad = 0;
        for (int k = 0; k < 480; k++) begin
            @(negedge clk_in);
            if (k == 99) begin
                qr_code  = put_fmt('1, 15'h77C4, 15'h77C4);
                valid_qr = 1'b1;
            end else begin
                valid_qr = 1'b0;
            end
            if (unmask_valid) begin pulses++; pulse_at = k; end
            if (busy !== (k < GOOD_LAT)) busy_bad++;
            if (k == GOOD_LAT) e = sb.pop_front();
        end
        checks++;
        if (pulses !== 1 || pulse_at !== GOOD_LAT) begin
            failures++;
            $display("FAIL t5_pulses actual count=%0d at=%0d required count=1 at=%0d", pulses, pulse_at, GOOD_LAT);
        end
        checks++;
        if (busy_bad !== 0) begin failures++; $display("FAIL t5_busy actual bad_cycles=%0d required 0", busy_bad); end
        checks++;
        if (unmasked_code !== e.grid || mask_id !== e.mask || ecc_level !== e.ecc) begin
            failures++;
            $display("FAIL t5_grid actual=%h required=%h", unmasked_code, e.grid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        int   pulses;
        @(posedge clk_in); #1;
        send(put_fmt(rand_grid(), 15'h5412, 15'h5412));
        repeat (199) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        sb.delete();
        @(negedge clk_in);
        checks++;
        if ({unmasked_code !== '0, ecc_level, mask_id, format_err, unmask_valid, busy} !== '0) begin
            failures++;
            $display("FAIL t6_reset actual ecc=%b mask=%b err=%b v=%b busy=%b grid_nonzero=%b required all 0",
                     ecc_level, mask_id, format_err, unmask_valid, busy, unmasked_code !== '0);
        end
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_in);
            if (unmask_valid || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL t6_no_pulse actual active_cycles=%0d required 0", pulses); end
        @(posedge clk_in); #1;
        send(put_fmt('0, 15'h77C4, 15'h77C4));
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== GOOD_LAT || unmasked_code !== e.grid) begin
            failures++;
            $display("FAIL t6_fresh actual lat=%0d grid=%h required lat=%0d grid=%h", lat, unmasked_code, GOOD_LAT, e.grid);
        end
    endtask

    task automatic test_all_masks();
        exp_t        e;
        int          lat;
        logic [14:0] f;
        for (int m = 0; m < 8; m++) begin
            @(posedge clk_in); #1;
            f = {2'($urandom), 3'(m), 10'($urandom)} ^ 15'h5412;
            send(put_fmt(rand_grid(), f, f));
            wait_done(lat);
            e = sb.pop_front();
            checks++;
            if (lat !== GOOD_LAT || mask_id !== e.mask || ecc_level !== e.ecc || format_err !== 1'b0) begin
                failures++;
                $display("FAIL mask%0d_fields actual lat=%0d ecc=%b mask=%0d err=%b required lat=%0d ecc=%b mask=%0d err=0",
                         m, lat, ecc_level, mask_id, format_err, GOOD_LAT, e.ecc, e.mask);
            end
            checks++;
            if (unmasked_code !== e.grid) begin
                failures++;
                $display("FAIL mask%0d_grid actual=%h required=%h", m, unmasked_code, e.grid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mask0_zero();
        test_format_err();
        test_mask1_ones();
        test_timing_row();
        test_busy_ignore();
        test_reset_mid();
        test_all_masks();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
